serial_to_parallel_regs: RTL

Serial-to-parallel input stage for the GF arithmetic datapath. It collects a serial bit stream, LSB first, into DATA_WIDTH-bit operand words and presents each completed word to the combinational GF core through a valid/ready holding register. Bit ordering mirrors the output serializer, so bit k of a frame lands in out_parallel[k]. Frame delineation, back-pressure and error flags are handled here so the core only ever sees complete words.

---
 rtl/serial_to_parallel_regs.sv | 64 ++++++
 1 files changed

// File: rtl/serial_to_parallel_regs.sv
// serial_to_parallel_regs: collects an LSB-first serial stream into words
// and offers each completed word through a valid/ready holding register.
module serial_to_parallel_regs #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_serial,
  input  logic                  in_valid,
  input  logic                  in_start,
  output logic [DATA_WIDTH-1:0] out_parallel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  err_clr
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, par_q, par_d;
  logic                  vld_q, vld_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic                  start, shift, last, load;
  always_comb begin
    start = in_valid & in_start;
    shift = in_valid & ~in_start & (state_q == SHIFT);
    last = shift & (cnt_q == CW'(DATA_WIDTH - 1));
    load = last & (~vld_q | out_ready);
    sr_d = sr_q;
    if (start) sr_d = {{(DATA_WIDTH-1){1'b0}}, in_serial};
    else if (shift) sr_d[cnt_q] = in_serial;
    cnt_d = start ? CW'(1) : last ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    state_d = start ? SHIFT : last ? IDLE : state_q;
    par_d = load ? {in_serial, sr_q[DATA_WIDTH-2:0]} : par_q;
    // a completion keeps out_valid high; otherwise a handshake drops it
    vld_d = load | (vld_q & ~out_ready);
    ovr_d = (last & ~load) | (ovr_q & ~err_clr);
    ferr_d = (start & (state_q == SHIFT)) | (ferr_q & ~err_clr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      par_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      par_q <= par_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
    end
  end
  assign out_parallel = par_q;
  assign out_valid = vld_q;
  assign overrun = ovr_q;
  assign frame_err = ferr_q;
endmodule
